instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
Converts decoded RV32I instruction fields (format, funct3, register indices, immediate) back into 32-bit instruction words. It is the inverse of the core's instruction decoder. Encoded words go through a small FIFO and are written sequentially into instruction memory through a stallable write port. It serves as the program loader and self-test generator for the CPU bench and boot path.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
BASE_ADDRESS, 32'h0000_0000, first instruction-memory byte address written after reset or restart.

Ports:
i_clk  input  1  clock, rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_restart  input  1  synchronous clear: empties FIFO, reloads address, clears error.
i_valid  input  1  input fields valid.
o_ready  output  1  encoder can accept.
i_format  input  3  0=OP-IMM, 1=OP, 2=BRANCH, 3=STORE, 4=JAL, 5-7 invalid.
i_funct3  input  3  funct3 field; ignored for JAL.
i_source_register1  input  5  rs1.
i_source_register2  input  5  rs2 (OP, BRANCH, STORE).
i_destination_register  input  5  rd (OP-IMM, OP, JAL).
i_immediate  input  32  sign-extended immediate or byte offset.
o_imem_write_enable  output  1  word presented to instruction memory.
i_imem_ready  input  1  memory accepts the word this cycle.
o_imem_address  output  32  byte address of the presented word.
o_imem_data  output  32  encoded instruction.
o_count  output  $clog2(DEPTH)+1  FIFO occupancy.
o_error  output  1  sticky: invalid format or immediate out of range.

Behaviour:
- Reset state: FIFO empty, o_count=0, o_imem_write_enable=0, o_imem_address=BASE_ADDRESS, o_imem_data=0, o_error=0, o_ready=1.
- Input accept: a transfer happens when i_valid && o_ready.
- o_ready = (o_count != DEPTH). It is driven from registered state only, with no combinational path from i_imem_ready.
- Encoding is combinational. The accepted word enters the FIFO at the accept edge.
- Latency: accepted at edge N, the word is visible on the memory port in cycle N+1 if the FIFO was empty.
- Opcodes: OP-IMM=0010011, OP=0110011, BRANCH=1100011, STORE=0100011, JAL=1101111.
- OP encodes funct7=0000000.
- Field placement follows RISC-V I/R/B/S/J formats:
  - I: imm[11:0] rs1 f3 rd op.
  - R: 0 rs2 rs1 f3 rd op.
  - B: imm[12|10:5] rs2 rs1 f3 imm[4:1|11] op.
  - S: imm[11:5] rs2 rs1 f3 imm[4:0] op.
  - J: imm[20|10:1|11|19:12] rd op.
- Invalid format (5-7): transfer is accepted (consumed) but not enqueued; o_error is set the next cycle.
- Memory write: o_imem_write_enable = FIFO not empty; o_imem_data = FIFO head; o_imem_address = current address.
- On o_imem_write_enable && i_imem_ready: pop the FIFO and add 4 to the address. Address wraps modulo 2^32 with no flag.
- Simultaneous push and pop: o_count is unchanged and both take effect. When full, o_ready=0 even if a pop occurs that cycle.
- i_restart: takes priority over push and pop that cycle. A push coincident with restart is discarded. Next cycle: FIFO empty, address=BASE_ADDRESS, o_error=0.
- Asynchronous reset mid-operation: all state returns to reset values immediately. A word being written is abandoned.
- FIFO pointers wrap modulo DEPTH. o_count is the authority for full and empty.

Optional Feature:
Macro: ENCODER_RANGE_CHECK_EN.
- Defined: an immediate not representable in its format is dropped (consumed, not enqueued) and o_error is set. Ranges:
  - I and S: -2048..2047.
  - B: -4096..4094, even.
  - J: -1048576..1048574, even.
- Undefined: no checks are made. Immediates are truncated to the format's bits and the LSB of B/J offsets is ignored. o_error reports invalid format only.

Test Plan:
- OP-IMM, funct3=0, rd=1, rs1=0, imm=5, i_imem_ready=1 -> word 0x00500093 at address 0x0 one cycle after accept; o_count returns to 0.
- OP, rd=3, rs1=1, rs2=2, funct3=0, then BRANCH funct3=1, rs1=1, rs2=2, imm=-8 -> 0x002081B3 at 0x0, then 0xFE209CE3 at 0x4.
- STORE funct3=2, rs1=1, rs2=2, imm=8, then JAL rd=1, imm=16 -> 0x0020A423, then 0x010000EF at consecutive addresses.
- DEPTH=4, i_imem_ready=0, push 5 valid words -> o_ready=0 after the 4th and the 5th is held. Then i_imem_ready=1 -> writes at 0x0, 0x4, 0x8, 0xC, then the 5th at 0x10; no word is lost or duplicated.
- With ENCODER_RANGE_CHECK_EN: OP-IMM imm=2048 -> no memory write, o_error=1. Then i_restart -> o_error=0, address=BASE_ADDRESS. Without the macro: the same input writes 0x80000093 (addi x1,x0,-2048).
- i_format=6, then asynchronous reset asserted while 3 words are queued -> o_error=1 before the reset. Reset clears o_error; o_count=0, o_imem_write_enable=0 immediately.

Source files
------------

// File: rtl/instruction_encoder.sv
// RV32I field-to-word encoder feeding a small FIFO that streams words into instruction memory.
// Optional build macro ENCODER_RANGE_CHECK_EN: drop and flag immediates that do not fit their format.
module instruction_encoder #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_restart,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [2:0]                 i_format,
  input  logic [2:0]                 i_funct3,
  input  logic [4:0]                 i_source_register1,
  input  logic [4:0]                 i_source_register2,
  input  logic [4:0]                 i_destination_register,
  input  logic [31:0]                i_immediate,
  output logic                       o_imem_write_enable,
  input  logic                       i_imem_ready,
  output logic [31:0]                o_imem_address,
  output logic [31:0]                o_imem_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_error
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    FMT_OP_IMM = 3'd0,
    FMT_OP     = 3'd1,
    FMT_BRANCH = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_JAL    = 3'd4
  } format_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [31:0] imm;
  logic [31:0] word;
  logic        format_ok;
  logic        imm_ok;

  assign rs1 = i_source_register1;
  assign rs2 = i_source_register2;
  assign rd  = i_destination_register;
  assign f3  = i_funct3;
  assign imm = i_immediate;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    word      = '0;
    format_ok = 1'b1;
    case (i_format)
      FMT_OP_IMM: word = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
      FMT_OP:     word = {7'b0000000, rs2, rs1, f3, rd, OPC_OP};
      FMT_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      FMT_STORE:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      FMT_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      default:    format_ok = 1'b0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // A value fits N signed bits when every bit above the sign bit copies it.
  logic fits_12, fits_13_even, fits_21_even;
  assign fits_12      = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13_even = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fits_21_even = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  always_comb begin
    imm_ok = 1'b1;
    case (i_format)
      FMT_OP_IMM, FMT_STORE: imm_ok = fits_12;
      FMT_BRANCH:            imm_ok = fits_13_even;
      FMT_JAL:               imm_ok = fits_21_even;
      default:               imm_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];
  assign imm_ok        = 1'b1;
`endif

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      addr_q, addr_d;
  logic             error_q, error_d;
  logic             accept, push, pop;

  assign o_ready = (count_q != CNT_W'(DEPTH));
  assign accept  = i_valid && o_ready;
  assign push    = accept && format_ok && imm_ok && !i_restart;
  assign pop     = (count_q != '0) && i_imem_ready && !i_restart;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    error_d  = error_q;
    if (i_restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDRESS;
      error_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + 32'd4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (accept && !(format_ok && imm_ok)) error_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDRESS;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      error_q  <= error_d;
    end
  end

  // NOTE: FIFO storage is not reset; its contents are only observed when count_q is non-zero.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign o_imem_write_enable = (count_q != '0);
  assign o_imem_data         = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
  assign o_imem_address      = addr_q;
  assign o_count             = count_q;
  assign o_error             = error_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: stimulus pushes expected words, a monitor pops them
// on each memory write. Follows ENCODER_RANGE_CHECK_EN the same way the design does.
module tb_instruction_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        valid = 1'b0;
  logic        imem_ready = 1'b0;
  logic [2:0]  fmt = '0, f3 = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] imm = '0;
  logic        ready, we, err;
  logic [31:0] addr, data;
  logic [2:0]  count;

  instruction_encoder #(.DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
    .i_clk                  (clk),
    .i_reset_n              (rst_n),
    .i_restart              (restart),
    .i_valid                (valid),
    .o_ready                (ready),
    .i_format               (fmt),
    .i_funct3               (f3),
    .i_source_register1     (rs1),
    .i_source_register2     (rs2),
    .i_destination_register (rd),
    .i_immediate            (imm),
    .o_imem_write_enable    (we),
    .i_imem_ready           (imem_ready),
    .o_imem_address         (addr),
    .o_imem_data            (data),
    .o_count                (count),
    .o_error                (err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_idx = '0;
  logic [31:0] mon_exp;
  logic        err_model = 1'b0;
  logic [31:0] golden = '0;
  bit          use_golden = 0;
  int          rdy_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoding built by shifting each field into its documented bit position.
  function automatic logic [31:0] model_word(input logic [2:0] f, input logic [2:0] fn3,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [4:0] d, input logic [31:0] im);
    logic [31:0] r1, r2, rdv, fv;
    r1 = 32'(s1); r2 = 32'(s2); rdv = 32'(d); fv = 32'(fn3);
    case (f)
      3'd0: return ((im & 32'hFFF) << 20) | (r1 << 15) | (fv << 12) | (rdv << 7) | 32'h13;
      3'd1: return (r2 << 20) | (r1 << 15) | (fv << 12) | (rdv << 7) | 32'h33;
      3'd2: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                 | (r1 << 15) | (fv << 12) | (((im >> 1) & 32'hF) << 8)
                 | (((im >> 11) & 32'h1) << 7) | 32'h63;
      3'd3: return (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (fv << 12)
                 | ((im & 32'h1F) << 7) | 32'h23;
      3'd4: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                 | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                 | (rdv << 7) | 32'h6F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_ok(input logic [2:0] f, input logic [31:0] im);
    int s;
    s = $signed(im);
    if (f > 3'd4) return 0;
`ifdef ENCODER_RANGE_CHECK_EN
    case (f)
      3'd0, 3'd3: return (s >= -2048) && (s <= 2047);
      3'd2:       return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      3'd4:       return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      default:    return 1;
    endcase
`else
    return (s == s);
`endif
  endfunction

  // Monitor: every accepted memory write must match the oldest expected word and next address.
  always @(negedge clk) begin
    if (!rst_n || restart) begin
      exp_q.delete();
      wr_idx = '0;
    end else if (we && imem_ready) begin
      if (exp_q.size() == 0) begin
        check("write_with_empty_scoreboard", 32'(we), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("imem_data", data, mon_exp);
        check("imem_address", addr, BASE + (wr_idx << 2));
        wr_idx = wr_idx + 32'd1;
      end
    end
  end

  // One clock of stimulus, entered and left 1 time unit after a rising edge.
  task automatic step(output bit accepted);
    case (rdy_mode)
      0:       imem_ready = 1'b0;
      1:       imem_ready = 1'b1;
      default: imem_ready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
    check("o_error", 32'(err), 32'(err_model));
    accepted = valid && ready;
    if (restart) begin
      err_model = 1'b0;
    end else if (accepted) begin
      if (model_ok(fmt, imm)) exp_q.push_back(use_golden ? golden : model_word(fmt, f3, rs1, rs2, rd, imm));
      else                    err_model = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [2:0] fn3, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [4:0] d, input logic [31:0] im);
    fmt = f; f3 = fn3; rs1 = s1; rs2 = s2; rd = d; imm = im;
  endtask

  task automatic wait_accept();
    bit acc;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    if (!acc) check("accept_timeout", 32'(ready), 32'd1);
    valid = 1'b0;
    use_golden = 0;
  endtask

  task automatic send(input logic [2:0] f, input logic [2:0] fn3, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d, input logic [31:0] im);
    set_fields(f, fn3, s1, s2, d, im);
    valid = 1'b1;
    wait_accept();
  endtask

  task automatic idle(input int n);
    bit acc;
    valid = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic do_restart();
    bit acc;
    set_fields(3'd1, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    valid   = 1'b1;
    restart = 1'b1;
    step(acc);
    restart = 1'b0;
    valid   = 1'b0;
    check("restart_count", 32'(count), 32'd0);
    check("restart_address", addr, BASE);
    check("restart_error", 32'(err), 32'd0);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = (32'h1 << bits) - 32'h1;
    v = v & m;
    if (v[bits-1]) v = v | ~m;
    return v;
  endfunction

  initial begin
    bit          acc;
    logic [2:0]  rf;
    logic [31:0] rimm;
    logic [31:0] edges [9];
    edges = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, -32'sd4096,
              32'd4095, 32'd1048574, -32'sd1048576};

    #3;
    check("reset_count", 32'(count), 32'd0);
    check("reset_we", 32'(we), 32'd0);
    check("reset_address", addr, BASE);
    check("reset_data", data, 32'h0);
    check("reset_error", 32'(err), 32'd0);
    check("reset_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 1;
    golden = 32'h00500093; use_golden = 1;
    send(3'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    check("latency_we", 32'(we), 32'd1);
    check("latency_data", data, 32'h00500093);
    idle(2);
    check("addi_count", 32'(count), 32'd0);

    do_restart();
    golden = 32'h002081B3; use_golden = 1;
    send(3'd1, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    golden = 32'hFE209CE3; use_golden = 1;
    send(3'd2, 3'd1, 5'd1, 5'd2, 5'd0, -32'sd8);
    idle(3);

    do_restart();
    golden = 32'h0020A423; use_golden = 1;
    send(3'd3, 3'd2, 5'd1, 5'd2, 5'd0, 32'd8);
    golden = 32'h010000EF; use_golden = 1;
    send(3'd4, 3'd0, 5'd0, 5'd0, 5'd1, 32'd16);
    idle(3);
    check("pairs_drained", 32'(exp_q.size()), 32'd0);

    do_restart();
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) send(3'd0, 3'd0, 5'd1, 5'd0, 5'(i + 1), 32'(i));
    check("full_ready_low", 32'(ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    set_fields(3'd0, 3'd0, 5'd2, 5'd0, 5'd9, 32'd99);
    valid = 1'b1;
    step(acc);
    check("held_while_full", 32'(acc), 32'd0);
    rdy_mode = 1;
    wait_accept();
    idle(6);
    check("full_write_total", wr_idx, 32'd5);
    check("full_count_end", 32'(count), 32'd0);

    do_restart();
`ifdef ENCODER_RANGE_CHECK_EN
    send(3'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    idle(2);
    check("range_no_write", wr_idx, 32'd0);
    check("range_error", 32'(err), 32'd1);
`else
    golden = 32'h80000093; use_golden = 1;
    send(3'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    idle(2);
    check("trunc_written", wr_idx, 32'd1);
    check("trunc_no_error", 32'(err), 32'd0);
`endif
    do_restart();

    rdy_mode = 2;
    for (int n = 0; n < 200; n++) begin
      rf = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0:       rimm = sext($urandom, 12);
        1:       rimm = sext($urandom, 13);
        2:       rimm = sext($urandom, 21);
        3:       rimm = edges[$urandom_range(0, 8)];
        default: rimm = $urandom;
      endcase
      send(rf, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rimm);
    end
    rdy_mode = 1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check("random_count_end", 32'(count), 32'd0);

    do_restart();
    rdy_mode = 0;
    send(3'd6, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    for (int i = 0; i < 3; i++) send(3'd1, 3'(i), 5'd4, 5'd5, 5'(i), 32'd0);
    idle(1);
    check("pre_reset_error", 32'(err), 32'd1);
    check("pre_reset_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_we", 32'(we), 32'd0);
    check("async_error", 32'(err), 32'd0);
    check("async_address", addr, BASE);
    check("async_ready", 32'(ready), 32'd1);
    err_model = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    check("post_reset_we", 32'(we), 32'd0);
    check("post_reset_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
